// File: rtl/detect_run.sv
// detect_run: run-length detector on a qualified serial bit stream.
//
// Raises dout in the same cycle that the RUN_LEN-th consecutive identical qualified bit arrives
// (Mealy output). Run tracking is independent of the value-selection mode, so a mode change
// mid-run takes effect on the very next identical bit.
//
// Build option: define DETECT_RUN_CNT_EN to build the saturating match counter. Without it,
// match_cnt is tied to zero and clr_cnt is ignored; the port list is the same in both builds.
//
// Parameters:
//   RUN_LEN   run length that triggers a match, 2..255
//   CNT_W     width of match_cnt
// Ports:
//   ck        clock, rising edge
//   rst       synchronous active-high reset; also forces dout low combinationally
//   en        sample qualifier; din is consumed only when en=1
//   din       serial data bit
//   mode      00 either value, 01 ones only, 10 zeros only, 11 matching disabled
//   ovl       1 overlapping matches, 0 non-overlapping
//   clr_cnt   synchronous clear of match_cnt (wins over an increment)
//   dout      match pulse
//   run_val   registered value of the run being tracked
//   match_cnt saturating count of matches
module detect_run #(
    parameter int unsigned RUN_LEN = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             ovl,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             run_val,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned LEN_W = $clog2(RUN_LEN + 1);
    localparam logic [LEN_W-1:0] LenMax = LEN_W'(RUN_LEN - 1);

    if ((RUN_LEN < 2) || (RUN_LEN > 255)) begin : gen_bad_run_len
        $error("detect_run: RUN_LEN must be in 2..255");
    end

    if (CNT_W < 1) begin : gen_bad_cnt_w
        $error("detect_run: CNT_W must be at least 1");
    end

    // StIdle: no run history; StRun: last_q/len_q describe a live run.
    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_ok;
    logic             same;
    logic             full;

    always_comb begin
        unique case (mode)
            2'b00:   mode_ok = 1'b1;
            2'b01:   mode_ok = din;
            2'b10:   mode_ok = ~din;
            default: mode_ok = 1'b0;
        endcase
    end

    assign same = (state_q == StRun) && (din == last_q);
    assign full = (len_q == LenMax);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        len_d   = len_q;
        dout    = 1'b0;
        if (en) begin
            if (!same) begin
                state_d = StRun;
                last_d  = din;
                len_d   = LEN_W'(1);
            end else if (!full) begin
                len_d = len_q + LEN_W'(1);
            end else if (mode_ok) begin
                dout = ~rst;
                // Non-overlapping: drop the history so the next bit opens a fresh run.
                if (!ovl) begin
                    state_d = StIdle;
                end
            end
            // A completed run that is masked by mode keeps len saturated at LenMax.
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    assign run_val = last_q;

`ifdef DETECT_RUN_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (dout && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_detect_run.sv
// Bench for detect_run: three instances (RUN_LEN 2/3/4) share one stimulus stream.
// Directed scenarios check fixed expected sequences; a randomized phase checks every output
// against a history-based reference model.
module tb_detect_run;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       ovl = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       dout2, dout3, dout4;
    logic       rv2, rv3, rv4;
    logic [1:0] cnt2;
    logic [7:0] cnt3, cnt4;

    int n_vec = 0;
    int n_err = 0;
    int cnt_on;

    always #5 ck = ~ck;

    detect_run #(.RUN_LEN(2), .CNT_W(2)) u_dut2 (
        .ck(ck), .rst(rst), .en(en), .din(din), .mode(mode), .ovl(ovl), .clr_cnt(clr_cnt),
        .dout(dout2), .run_val(rv2), .match_cnt(cnt2)
    );
    detect_run #(.RUN_LEN(3), .CNT_W(8)) u_dut3 (
        .ck(ck), .rst(rst), .en(en), .din(din), .mode(mode), .ovl(ovl), .clr_cnt(clr_cnt),
        .dout(dout3), .run_val(rv3), .match_cnt(cnt3)
    );
    detect_run #(.RUN_LEN(4), .CNT_W(8)) u_dut4 (
        .ck(ck), .rst(rst), .en(en), .din(din), .mode(mode), .ovl(ovl), .clr_cnt(clr_cnt),
        .dout(dout4), .run_val(rv4), .match_cnt(cnt4)
    );

    // Reference model: the list of all qualified bits since reset, plus per instance the
    // position after its last non-overlapping match (bits before it cannot join a run).
    bit qhist[$];
    int brk[3];
    int mcnt[3];
    bit mlast;

    function automatic int len_of(int k);
        return k + 2;
    endfunction

    function automatic int cap_of(int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic bit mode_ok_f(logic [1:0] m, bit d);
        return (m == 2'b00) || (m == 2'b01 && d) || (m == 2'b10 && !d);
    endfunction

    // Length of the run of value d ending with the current bit.
    function automatic int trail(int k, bit d);
        int n = 1;
        for (int i = qhist.size() - 1; i >= brk[k]; i--) begin
            if (qhist[i] != d) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit exp_dout(int k);
        return !rst && en && mode_ok_f(mode, din) && (trail(k, din) >= len_of(k));
    endfunction

    function automatic int exp_cnt(int k);
        return (cnt_on != 0) ? mcnt[k] : 0;
    endfunction

    task automatic drive(bit r, bit e, bit d, logic [1:0] m, bit o, bit c);
        rst     = r;
        en      = e;
        din     = d;
        mode    = m;
        ovl     = o;
        clr_cnt = c;
        @(negedge ck);
    endtask

    task automatic tick();
        bit hit[3];
        for (int k = 0; k < 3; k++) hit[k] = exp_dout(k);
        @(posedge ck);
        if (rst) begin
            qhist.delete();
            for (int k = 0; k < 3; k++) begin
                brk[k]  = 0;
                mcnt[k] = 0;
            end
            mlast = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr_cnt) mcnt[k] = 0;
                else if (hit[k] && mcnt[k] < cap_of(k)) mcnt[k]++;
            end
            if (en) begin
                qhist.push_back(din);
                mlast = din;
                for (int k = 0; k < 3; k++) begin
                    if (hit[k] && !ovl) brk[k] = qhist.size();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bit ds[6] = '{0, 0, 1, 1, 1, 0};
        bit ed[6] = '{0, 1, 0, 1, 1, 0};
        bit er[6] = '{0, 0, 0, 1, 1, 1};
        int ec[6] = '{0, 0, 1, 1, 2, 3};
        drive(1, 1, 1, 2'b00, 1, 0);
        n_vec++;
        if (dout2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dout_1: dout=%b required 0", dout2);
        end
        tick();
        drive(1, 1, 1, 2'b00, 1, 0);
        n_vec++;
        if (dout2 !== 1'b0 || rv2 !== 1'b0 || cnt2 !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: dout=%b run_val=%b cnt=%0d required 0/0/0",
                     dout2, rv2, cnt2);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, ds[i], 2'b00, 1, 0);
            n_vec++;
            if (dout2 !== ed[i] || rv2 !== er[i]) begin
                n_err++;
                $display("FAIL reset_seq bit %0d: dout=%b run_val=%b required %b/%b",
                         i + 1, dout2, rv2, ed[i], er[i]);
            end
            n_vec++;
            if (cnt2 !== ((cnt_on != 0) ? ec[i] : 0)) begin
                n_err++;
                $display("FAIL reset_seq_cnt bit %0d: cnt=%0d required %0d",
                         i + 1, cnt2, (cnt_on != 0) ? ec[i] : 0);
            end
            tick();
        end
    endtask

    task automatic test_overlap();
        for (int pass = 0; pass < 2; pass++) begin
            bit o = (pass == 0);
            drive(1, 0, 0, 2'b00, o, 0);
            tick();
            for (int i = 0; i < 7; i++) begin
                bit e = o ? (i >= 2) : (i == 2 || i == 5);
                drive(0, 1, 1, 2'b00, o, 0);
                n_vec++;
                if (dout3 !== e) begin
                    n_err++;
                    $display("FAIL overlap ovl=%0d bit %0d: dout=%b required %b",
                             o, i + 1, dout3, e);
                end
                tick();
            end
            drive(0, 0, 0, 2'b00, o, 0);
            n_vec++;
            if (cnt3 !== ((cnt_on != 0) ? (o ? 5 : 2) : 0)) begin
                n_err++;
                $display("FAIL overlap_cnt ovl=%0d: cnt=%0d required %0d",
                         o, cnt3, (cnt_on != 0) ? (o ? 5 : 2) : 0);
            end
            tick();
        end
    endtask

    task automatic test_mode();
        bit         ds[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        logic [1:0] ms[8] = '{1, 1, 1, 1, 1, 3, 3, 0};
        bit         ed[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        drive(1, 0, 0, 2'b01, 1, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, ds[i], ms[i], 1, 0);
            n_vec++;
            if (dout2 !== ed[i]) begin
                n_err++;
                $display("FAIL mode bit %0d mode=%0d: dout=%b required %b",
                         i + 1, ms[i], dout2, ed[i]);
            end
            tick();
        end
    endtask

    task automatic test_gaps();
        bit es[6] = '{1, 0, 0, 1, 0, 1};
        bit ed[6] = '{0, 0, 0, 0, 0, 1};
        drive(1, 0, 0, 2'b00, 1, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            // Gap cycles carry the opposite value to show unqualified bits are ignored.
            drive(0, es[i], es[i], 2'b00, 1, 0);
            n_vec++;
            if (dout3 !== ed[i] || dout4 !== 1'b0) begin
                n_err++;
                $display("FAIL gaps cycle %0d en=%b: dout3=%b dout4=%b required %b/0",
                         i + 1, es[i], dout3, dout4, ed[i]);
            end
            tick();
        end
    endtask

    task automatic test_counter();
        bit ed[6] = '{0, 1, 1, 1, 1, 1};
        int ec[6] = '{0, 0, 1, 2, 3, 3};
        drive(1, 0, 0, 2'b00, 1, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 2'b00, 1, 0);
            n_vec++;
            if (dout2 !== ed[i] || cnt2 !== ((cnt_on != 0) ? ec[i] : 0)) begin
                n_err++;
                $display("FAIL counter bit %0d: dout=%b cnt=%0d required %b/%0d",
                         i + 1, dout2, cnt2, ed[i], (cnt_on != 0) ? ec[i] : 0);
            end
            tick();
        end
        drive(0, 1, 0, 2'b00, 1, 1);
        n_vec++;
        if (dout2 !== 1'b1 || cnt2 !== ((cnt_on != 0) ? 3 : 0)) begin
            n_err++;
            $display("FAIL counter_sat: dout=%b cnt=%0d required 1/%0d",
                     dout2, cnt2, (cnt_on != 0) ? 3 : 0);
        end
        tick();
        drive(0, 0, 0, 2'b00, 1, 0);
        n_vec++;
        if (cnt2 !== 2'd0) begin
            n_err++;
            $display("FAIL counter_clr: cnt=%0d required 0", cnt2);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit ed[4] = '{0, 0, 0, 1};
        drive(1, 0, 0, 2'b00, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 2'b00, 1, 0);
            n_vec++;
            if (dout4 !== 1'b0) begin
                n_err++;
                $display("FAIL midrun_pre bit %0d: dout=%b required 0", i + 1, dout4);
            end
            tick();
        end
        drive(1, 1, 1, 2'b00, 1, 0);
        n_vec++;
        if (dout4 !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_rst: dout=%b required 0", dout4);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 2'b00, 1, 0);
            n_vec++;
            if (dout4 !== ed[i]) begin
                n_err++;
                $display("FAIL midrun_post bit %0d: dout=%b required %b", i + 1, dout4, ed[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit         d = 1'b0;
        bit         o = 1'b1;
        logic [1:0] m = 2'b00;
        drive(1, 0, 0, 2'b00, 1, 0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            bit r = ($urandom_range(0, 99) < 2);
            bit e = ($urandom_range(0, 3) != 0);
            bit c = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) >= 7) d = ~d;
            if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) o = ~o;
            drive(r, e, d, m, o, c);
            n_vec++;
            if (dout2 !== exp_dout(0) || dout3 !== exp_dout(1) || dout4 !== exp_dout(2)) begin
                n_err++;
                $display("FAIL rand_dout cyc %0d: got %b%b%b required %b%b%b", i,
                         dout2, dout3, dout4, exp_dout(0), exp_dout(1), exp_dout(2));
            end
            n_vec++;
            if (rv2 !== mlast || rv3 !== mlast || rv4 !== mlast) begin
                n_err++;
                $display("FAIL rand_run_val cyc %0d: got %b%b%b required %b",
                         i, rv2, rv3, rv4, mlast);
            end
            n_vec++;
            if (cnt2 !== exp_cnt(0) || cnt3 !== exp_cnt(1) || cnt4 !== exp_cnt(2)) begin
                n_err++;
                $display("FAIL rand_cnt cyc %0d: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                         cnt2, cnt3, cnt4, exp_cnt(0), exp_cnt(1), exp_cnt(2));
            end
            tick();
        end
    endtask

    initial begin
`ifdef DETECT_RUN_CNT_EN
        cnt_on = 1;
`else
        cnt_on = 0;
`endif
        test_reset();
        test_overlap();
        test_mode();
        test_gaps();
        test_counter();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
